// File: rtl/msg_ram_arbiter.sv
// rtl/msg_ram_arbiter.sv - message RAM arbiter: clear sweep, write/read grants, address limit
// Optional ARB_RR_EN: round-robin write/read contention instead of fixed write-over-read priority.
module msg_ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int LIMIT  = 160
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              wr_drop,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  localparam logic [ADDR_W:0] LIMIT_EXT = LIMIT[ADDR_W:0];

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W:0]   sweep_cnt;
  logic [ADDR_W:0]   sweep_cnt_nxt;
  logic              sweep_end;
  logic              sweep_we;
  logic              arb_busy;
  logic              grant_wr;
  logic              grant_rd;
  logic              wr_in_range;
  logic [DATA_W-1:0] rd_hold;

`ifdef ARB_RR_EN
  logic              prio_wr;
`endif

  // Extra counter bit marks "address 2^ADDR_W-1 already written".
  assign sweep_end   = sweep_cnt[ADDR_W];
  assign wr_in_range = ({1'b0, wr_addr} < LIMIT_EXT);
  // A grant occupies its cycle; no new winner is picked while any gnt is high.
  assign arb_busy    = wr_gnt | rd_gnt;
  assign clr_busy    = (state == ST_CLEAR);
  assign rd_data     = rd_valid ? ram_dout : rd_hold;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state     <= ST_CLEAR;
      sweep_cnt <= '0;
    end else begin
      state     <= state_nxt;
      sweep_cnt <= sweep_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sweep_cnt_nxt = sweep_cnt;
    sweep_we      = 1'b0;
    grant_wr      = 1'b0;
    grant_rd      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt     = ST_CLEAR;
          sweep_cnt_nxt = '0;
        end else if (!arb_busy) begin
`ifdef ARB_RR_EN
          if (wr_req && rd_req) begin
            grant_wr = prio_wr;
            grant_rd = ~prio_wr;
          end else begin
            grant_wr = wr_req;
            grant_rd = rd_req;
          end
`else
          grant_wr = wr_req;
          grant_rd = rd_req & ~wr_req;
`endif
        end
      end
      ST_CLEAR: begin
        if (sweep_end) begin
          state_nxt     = ST_IDLE;
          sweep_cnt_nxt = '0;
        end else begin
          sweep_we      = 1'b1;
          sweep_cnt_nxt = sweep_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt     = ST_CLEAR;
        sweep_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      wr_gnt   <= 1'b0;
      wr_drop  <= 1'b0;
      rd_gnt   <= 1'b0;
      rd_valid <= 1'b0;
      clr_done <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      rd_hold  <= '0;
    end else begin
      wr_gnt   <= grant_wr;
      wr_drop  <= grant_wr & ~wr_in_range;
      rd_gnt   <= grant_rd;
      rd_valid <= rd_gnt;
      clr_done <= (state == ST_CLEAR) && sweep_end;
      ram_we   <= sweep_we | (grant_wr & wr_in_range);
      if (sweep_we) begin
        ram_addr <= sweep_cnt[ADDR_W-1:0];
        ram_din  <= '0;
      end else if (grant_wr) begin
        ram_addr <= wr_addr;
        ram_din  <= wr_data;
      end else if (grant_rd) begin
        ram_addr <= rd_addr;
      end
      if (rd_valid) begin
        rd_hold <= ram_dout;
      end
    end
  end

`ifdef ARB_RR_EN
  // Pointer favours whichever side was not granted last.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      prio_wr <= 1'b1;
    end else if (grant_wr) begin
      prio_wr <= 1'b0;
    end else if (grant_rd) begin
      prio_wr <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_msg_ram_arbiter.sv
// tb/tb_msg_ram_arbiter.sv - self-checking bench for msg_ram_arbiter with RAM and shadow-memory model
module tb_msg_ram_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int LIMIT  = 160;

  logic              sysclk = 1'b0;
  logic              reset;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;
  logic              wr_drop;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  logic [DATA_W-1:0] mem     [0:255];
  logic [DATA_W-1:0] exp_mem [0:255];
  int                n_checks = 0;
  int                n_errors = 0;
  bit                favour_wr;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] d;
  bit                w;

  msg_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LIMIT(LIMIT)) dut (
    .sysclk(sysclk), .reset(reset), .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt), .wr_drop(wr_drop),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge sysclk);
    #1;
  endtask

  // Expected winner when both sides request at once.
  function automatic bit pick_wr();
`ifdef ARB_RR_EN
    return favour_wr;
`else
    return 1'b1;
`endif
  endfunction

  // Watches a full sweep, returns one cycle after clr_done.
  task automatic run_sweep(input string tag);
    int writes = 0;
    int order_err = 0;
    int busy_err = 0;
    int gnt_seen = 0;
    int cyc = 0;
    bit done_seen = 0;
    while (!done_seen && cyc < 400) begin
      tick;
      cyc++;
      if (ram_we) begin
        if (ram_addr !== writes[ADDR_W-1:0] || ram_din !== '0) order_err++;
        if (clr_busy !== 1'b1) busy_err++;
        writes++;
      end
      if (wr_gnt || rd_gnt) gnt_seen++;
      if (clr_done === 1'b1) done_seen = 1;
    end
    check({tag, "_done_seen"}, done_seen, 1);
    check({tag, "_writes"}, writes, 256);
    check({tag, "_order"}, order_err, 0);
    check({tag, "_busy"}, busy_err, 0);
    check({tag, "_no_gnt"}, gnt_seen, 0);
    check({tag, "_busy_at_done"}, clr_busy, 0);
    check({tag, "_we_at_done"}, ram_we, 0);
    for (int i = 0; i < 256; i++) exp_mem[i] = '0;
    tick;
    check({tag, "_done_pulse"}, clr_done, 0);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    bit in_range;
    in_range = (int'(addr) < LIMIT);
    wr_req = 1; wr_addr = addr; wr_data = data;
    tick;
    check("wr_gnt", wr_gnt, 1);
    check("wr_drop", wr_drop, !in_range);
    check("wr_we", ram_we, in_range);
    check("wr_addr", ram_addr, addr);
    check("wr_din", ram_din, data);
    check("wr_no_rd_gnt", rd_gnt, 0);
    wr_req = 0;
    if (in_range) exp_mem[addr] = data;
    favour_wr = 0;
    tick;
    check("wr_gnt_pulse", wr_gnt, 0);
    check("wr_we_off", ram_we, 0);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr);
    rd_req = 1; rd_addr = addr;
    tick;
    check("rd_gnt", rd_gnt, 1);
    check("rd_we", ram_we, 0);
    check("rd_addr", ram_addr, addr);
    check("rd_valid_early", rd_valid, 0);
    rd_req = 0;
    favour_wr = 1;
    tick;
    check("rd_valid", rd_valid, 1);
    check("rd_data", rd_data, exp_mem[addr]);
    check("rd_gnt_pulse", rd_gnt, 0);
    tick;
    check("rd_valid_pulse", rd_valid, 0);
    check("rd_data_hold", rd_data, exp_mem[addr]);
  endtask

  // Both requests held; grants every other cycle, winner from the arbitration rule.
  task automatic contend(input int cycles, input string tag);
    bit ew;
    for (int i = 0; i < cycles; i++) begin
      tick;
      if (i % 2 == 0) begin
        ew = pick_wr();
        check({tag, "_wgnt"}, wr_gnt, ew);
        check({tag, "_rgnt"}, rd_gnt, !ew);
        check({tag, "_addr"}, ram_addr, ew ? wr_addr : rd_addr);
        if (ew) exp_mem[wr_addr] = wr_data;
        favour_wr = !ew;
      end else begin
        check({tag, "_gap"}, wr_gnt | rd_gnt, 0);
      end
    end
  endtask

  initial begin
    reset = 1; clr_req = 0; wr_req = 0; wr_addr = '0; wr_data = '0; rd_req = 0; rd_addr = '0;
    for (int i = 0; i < 256; i++) exp_mem[i] = '0;
    tick;
    tick;
    check("rst_busy", clr_busy, 1);
    check("rst_we", ram_we, 0);
    check("rst_gnt", {wr_gnt, rd_gnt, wr_drop, rd_valid, clr_done}, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_din", ram_din, 0);
    check("rst_rdata", rd_data, 0);
    reset = 0;
    favour_wr = 1;
    run_sweep("por");

    do_write(8'h05, 16'h8041);
    do_write(8'd160, 16'($urandom));
    do_write(8'd159, 16'($urandom));
    do_read(8'h05);
    do_read(8'd160);
    do_read(8'd159);

    wr_addr = 8'($urandom_range(0, LIMIT - 1)); wr_data = 16'($urandom); rd_addr = 8'h05;
    wr_req = 1; rd_req = 1;
    contend(8, "hold");
    a = wr_addr;
    wr_req = 0; rd_req = 0;
    tick;
    do_read(a);

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0: a = 8'(LIMIT - 1);
        1: a = 8'(LIMIT);
        2: a = 8'hFF;
        default: a = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 1) == 0) do_write(a, 16'($urandom));
      else do_read(a);
    end

    a = 8'($urandom_range(0, LIMIT - 1)); d = 16'($urandom);
    wr_req = 1; wr_addr = a; wr_data = d; clr_req = 1;
    tick;
    check("clrwin_gnt", wr_gnt, 0);
    check("clrwin_busy", clr_busy, 1);
    clr_req = 0;
    run_sweep("clrwin");
    check("clrwin_pend_gnt", wr_gnt, 1);
    check("clrwin_pend_addr", ram_addr, a);
    check("clrwin_pend_we", ram_we, 1);
    wr_req = 0;
    exp_mem[a] = d;
    favour_wr = 0;
    tick;
    do_read(a);

    wr_addr = 8'($urandom_range(0, LIMIT - 1)); wr_data = 16'($urandom); rd_addr = 8'($urandom);
    wr_req = 1; rd_req = 1;
    contend(3, "mid");
    clr_req = 1;
    tick;
    clr_req = 0;
    check("mid_stop", wr_gnt | rd_gnt, 0);
    check("mid_busy", clr_busy, 1);
    run_sweep("mid");
    w = pick_wr();
    check("mid_resume_w", wr_gnt, w);
    check("mid_resume_r", rd_gnt, !w);
    if (w) exp_mem[wr_addr] = wr_data;
    favour_wr = !w;
    a = wr_addr;
    wr_req = 0; rd_req = 0;
    tick;
    tick;
    do_read(a);

    clr_req = 1;
    tick;
    clr_req = 0;
    for (int i = 0; i < 10; i++) tick;
    reset = 1;
    tick;
    check("rerst_busy", clr_busy, 1);
    check("rerst_we", ram_we, 0);
    reset = 0;
    favour_wr = 1;
    run_sweep("rerst");
    do_read(8'h05);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/msg_ram_arbiter.md
MSG_RAM_ARBITER -- requirements
Module: msg_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, 8, message RAM address width (256 entries).
REQ-002 Parameter DATA_W, 16, RAM word width (bit 15 = entry-valid flag, bits 7:0 = character).
REQ-003 Parameter LIMIT, 160, first address at which writes are refused.
REQ-004 Port sysclk  in  1  single system clock; all logic on its rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port clr_req  in  1  request full-RAM clear sweep.
REQ-007 Port clr_busy  out  1  high while a clear sweep runs.
REQ-008 Port clr_done  out  1  one-cycle pulse after the last clear write.
REQ-009 Port wr_req / wr_addr / wr_data  in  1 / ADDR_W / DATA_W  write request from serial receive path.
REQ-010 Port wr_gnt  out  1  one-cycle pulse: write request accepted.
REQ-011 Port wr_drop  out  1  one-cycle pulse with wr_gnt when wr_addr >= LIMIT.
REQ-012 Port rd_req / rd_addr  in  1 / ADDR_W  read request from playback path.
REQ-013 Port rd_gnt  out  1  one-cycle pulse: read issued to RAM.
REQ-014 Port rd_data / rd_valid  out  DATA_W / 1  read result, valid one cycle after rd_gnt.
REQ-015 Port ram_we / ram_addr / ram_din  out  1 / ADDR_W / DATA_W  RAM port, all registered.
REQ-016 Port ram_dout  in  DATA_W  RAM read data, one-cycle latency from ram_addr.

Function
REQ-017 States IDLE and CLEAR only; IDLE->CLEAR on clr_req; CLEAR->IDLE after address 2^ADDR_W-1 written.
REQ-018 CLEAR: ram_we=1, ram_din=0, ram_addr=sweep counter 0,1,...,255, one address per cycle; 256 write cycles exactly.
REQ-019 clr_busy high in every CLEAR cycle; clr_done pulses the cycle after the write to address 255, together with return to IDLE.
REQ-020 clr_req during CLEAR ignored (no restart); wr_gnt/rd_gnt held low during CLEAR; pending requests served after.
REQ-021 IDLE: requests sampled cycle N; winner's ram_* and gnt driven cycle N+1; at most one RAM access per cycle.
REQ-022 A requester whose gnt is high this cycle is not eligible this cycle (req held over gnt is a new request, earliest next grant two cycles later).
REQ-023 Write grant: ram_addr=wr_addr, ram_din=wr_data, ram_we=1 if wr_addr < LIMIT; else ram_we=0 and wr_drop=1.
REQ-024 Read grant: ram_we=0, ram_addr=rd_addr; next cycle rd_valid=1, rd_data=ram_dout; rd_data holds last value otherwise.
REQ-025 Non-granted cycles: ram_we=0, ram_addr and ram_din hold previous values.
REQ-026 clr_req simultaneous with wr_req/rd_req in IDLE: clear wins; requests wait.
REQ-027 Requests withdrawn before grant are dropped silently; arbiter keeps no queue.
REQ-028 Address compare unsigned, ADDR_W bits; sweep counter wraps to 0 on exit.

Reset
REQ-029 reset forces state CLEAR with sweep counter 0 (RAM cleared automatically after reset); reset during an active sweep restarts it at 0.
REQ-030 During and after reset: wr_gnt, rd_gnt, wr_drop, rd_valid, clr_done, ram_we = 0; rd_data, ram_addr, ram_din = 0; clr_busy = 1 from the first cycle after reset.

Configuration
REQ-031 Macro ARB_RR_EN defined: write/read contention resolved round-robin, priority to the requester not granted last; pointer resets to favour write.
REQ-032 ARB_RR_EN undefined: fixed priority, write over read; read may starve while wr_req is continuously re-asserted.

Verification
REQ-033 Reset 1 cycle, release -> clr_busy 256 cycles, ram_we=1 with addr 0..255, data 0; clr_done pulse; then IDLE.
REQ-034 IDLE, wr_req addr 0x05 data 0x8041 -> next cycle wr_gnt=1, ram_we=1, ram_addr=0x05, ram_din=0x8041; wr_drop=0.
REQ-035 wr_req addr 160 (0xA0) -> wr_gnt=1, wr_drop=1, ram_we=0; addr 159 -> written normally.
REQ-036 rd_req addr 0x05 after REQ-034 write -> rd_gnt, then rd_valid with rd_data=0x8041.
REQ-037 wr_req and rd_req held high 8 cycles -> ARB_RR_EN: alternating W,R grants; undefined: writes only; clr_req mid-stream -> grants stop within 1 cycle, resume after clr_done.
